// File: rtl/result_display_if.sv
// rtl/result_display_if.sv - result/display bundle between the controller and the display driver
//
// Signals:
//   result_valid   single-cycle strobe, result_in valid
//   result_in      classification result, 0-9 legal
//   clear          synchronous clear of history and flags
//   status_code    FSM status code shown by the overlay
//   show_status    1 = digit 0 shows status_code in hex
//   seg            segments {g,f,e,d,c,b,a}, active-low
//   an             digit anodes, active-low
//   decimalPoint   decimal point, active-low
//   history_count  number of valid history entries, 0-4
//   bad_result     sticky illegal-result flag
interface result_display_if;
  logic       result_valid;
  logic [3:0] result_in;
  logic       clear;
  logic [3:0] status_code;
  logic       show_status;
  logic [6:0] seg;
  logic [3:0] an;
  logic       decimalPoint;
  logic [2:0] history_count;
  logic       bad_result;

  modport master (
    output result_valid, result_in, clear, status_code, show_status,
    input  seg, an, decimalPoint, history_count, bad_result
  );

  modport slave (
    input  result_valid, result_in, clear, status_code, show_status,
    output seg, an, decimalPoint, history_count, bad_result
  );
endinterface

// File: rtl/result_display_driver.sv
// rtl/result_display_driver.sv - 4-deep result history multiplexed onto a 4-digit seven-segment display
//
// Ports:
//   clk   system clock
//   rst   synchronous reset, active-high
//   bus   result_display_if.slave: result strobe/value, clear, status overlay
//         controls in; seg/an/decimalPoint, history_count, bad_result out
//
// Newest result sits on an[3], oldest on an[0]. seg/an/decimalPoint are
// registered, so they show the state of the previous cycle.
module result_display_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter int NEW_HOLD     = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  result_display_if.slave   bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int NW = $clog2(NEW_HOLD + 1);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END    = CW'(BLANK_CYCLES);
  localparam logic [NW-1:0] HOLD_LOAD    = NW'(NEW_HOLD);

  logic [CW-1:0] r_refresh_cnt;
  logic [1:0]    r_digit_sel;
  logic [3:0]    r_hist [4];
  logic [3:0]    r_hvalid;
  logic [2:0]    r_history_count;
  logic          r_bad_result;
  logic [NW-1:0] r_new_cnt;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_dp;

  logic          w_capture;
  logic          w_illegal;
  logic          w_show_status;
  logic [3:0]    w_code;
  logic [6:0]    w_seg_next;
  logic [3:0]    w_an_next;
  logic          w_dp_next;

  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    case (v)
      4'h0: seg_encode = 7'h40;
      4'h1: seg_encode = 7'h79;
      4'h2: seg_encode = 7'h24;
      4'h3: seg_encode = 7'h30;
      4'h4: seg_encode = 7'h19;
      4'h5: seg_encode = 7'h12;
      4'h6: seg_encode = 7'h02;
      4'h7: seg_encode = 7'h78;
      4'h8: seg_encode = 7'h00;
      4'h9: seg_encode = 7'h10;
      4'hA: seg_encode = 7'h08;
      4'hB: seg_encode = 7'h03;
      4'hC: seg_encode = 7'h46;
      4'hD: seg_encode = 7'h21;
      4'hE: seg_encode = 7'h06;
      default: seg_encode = 7'h0E;
    endcase
  endfunction

  // Clear outranks any result arriving in the same cycle.
  assign w_capture = bus.result_valid && (bus.result_in <= 4'd9) && !bus.clear;
  assign w_illegal = bus.result_valid && (bus.result_in > 4'd9);

  // Scan timing keeps running through clear so the display never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= 2'd0;
    end else if (r_refresh_cnt == REFRESH_LAST) begin
      r_refresh_cnt <= '0;
      r_digit_sel   <= r_digit_sel + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      for (int i = 0; i < 4; i++) r_hist[i] <= 4'd0;
      r_hvalid        <= 4'd0;
      r_history_count <= 3'd0;
      r_bad_result    <= 1'b0;
      r_new_cnt       <= '0;
    end else begin
      if (w_capture) begin
        r_hist[0]   <= r_hist[1];
        r_hist[1]   <= r_hist[2];
        r_hist[2]   <= r_hist[3];
        r_hist[3]   <= bus.result_in;
        r_hvalid    <= {1'b1, r_hvalid[3:1]};
        r_new_cnt   <= HOLD_LOAD;
        if (r_history_count != 3'd4) r_history_count <= r_history_count + 3'd1;
      end else if (r_new_cnt != '0) begin
        r_new_cnt <= r_new_cnt - NW'(1);
      end
      if (w_illegal) r_bad_result <= 1'b1;
    end
  end

  always_comb begin
    w_show_status = bus.show_status && (r_digit_sel == 2'd0);
    w_code        = w_show_status ? bus.status_code : r_hist[r_digit_sel];
    w_seg_next    = (w_show_status || r_hvalid[r_digit_sel]) ? seg_encode(w_code) : 7'h7F;
    w_an_next     = ~(4'b0001 << r_digit_sel);
    w_dp_next     = !((r_digit_sel == 2'd3) && (r_new_cnt != '0) && r_hvalid[3]);
    // Anti-ghosting: all anodes off at the start of every slot.
    if (r_refresh_cnt < BLANK_END) begin
      w_seg_next = 7'h7F;
      w_an_next  = 4'hF;
      w_dp_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= 7'h7F;
      r_an  <= 4'hF;
      r_dp  <= 1'b1;
    end else begin
      r_seg <= w_seg_next;
      r_an  <= w_an_next;
      r_dp  <= w_dp_next;
    end
  end

  assign bus.seg           = r_seg;
  assign bus.an            = r_an;
  assign bus.decimalPoint  = r_dp;
  assign bus.history_count = r_history_count;
  assign bus.bad_result    = r_bad_result;

endmodule

// File: tb/tb_result_display_driver.sv
// tb/tb_result_display_driver.sv - randomized self-checking bench for result_display_driver
module tb_result_display_driver;

  localparam int RDIV  = 8;
  localparam int BLANK = 2;
  localparam int HOLD  = 20;

  logic clk;
  logic rst;
  result_display_if bus();

  result_display_driver #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK),
    .NEW_HOLD    (HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: scan position as a cycle count, history as a queue.
  int t;
  int q[$];
  bit m_bad;
  int m_new;
  logic [6:0] seg_tab [16];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    int slot, ph, n;
    e_seg = 7'h7F;
    e_an  = 4'hF;
    e_dp  = 1'b1;
    if (!rst) begin
      slot = (t / RDIV) % 4;
      ph   = t % RDIV;
      n    = q.size();
      if (ph >= BLANK) begin
        e_an[slot] = 1'b0;
        if (bus.show_status && slot == 0) e_seg = seg_tab[bus.status_code];
        else if (slot >= 4 - n)           e_seg = seg_tab[q[slot - (4 - n)]];
        e_dp = !(slot == 3 && m_new != 0 && n > 0);
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      t = 0; q.delete(); m_bad = 0; m_new = 0;
    end else begin
      t = (t + 1) % (4 * RDIV);
      if (bus.clear) begin
        q.delete(); m_bad = 0; m_new = 0;
      end else if (bus.result_valid && bus.result_in <= 9) begin
        q.push_back(int'(bus.result_in));
        if (q.size() > 4) void'(q.pop_front());
        m_new = HOLD;
      end else begin
        if (bus.result_valid) m_bad = 1;
        if (m_new > 0) m_new--;
      end
    end
    check_eq("seg", bus.seg, e_seg);
    check_eq("an", bus.an, e_an);
    check_eq("dp", bus.decimalPoint, e_dp);
    check_eq("history_count", bus.history_count, q.size());
    check_eq("bad_result", bus.bad_result, m_bad);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic strobe(input logic [3:0] v);
    bus.result_valid = 1'b1;
    bus.result_in    = v;
    step();
    bus.result_valid = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    t = 0; m_bad = 0; m_new = 0;
    rst = 1'b1;
    bus.result_valid = 1'b0;
    bus.result_in    = 4'd0;
    bus.clear        = 1'b0;
    bus.status_code  = 4'd0;
    bus.show_status  = 1'b0;

    // Reset and first blank scan
    idle(3);
    rst = 1'b0;
    idle(40);

    // Capture sequence saturating the history
    for (int v = 1; v <= 5; v++) begin
      strobe(4'(v));
      idle(9);
    end
    idle(32);

    // New-result flag, single and re-triggered
    strobe(4'd7);
    idle(40);
    strobe(4'd3);
    idle(4);
    strobe(4'd8);
    idle(40);

    // Illegal value, then clear racing a valid result
    strobe(4'd12);
    idle(16);
    bus.clear = 1'b1;
    strobe(4'd6);
    bus.clear = 1'b0;
    idle(32);

    // Status overlay over a held 9
    strobe(4'd9);
    bus.show_status = 1'b1;
    bus.status_code = 4'hA;
    idle(40);
    bus.show_status = 1'b0;
    idle(40);

    // Clear pulses mid-scan
    for (int k = 0; k < 5; k++) begin
      strobe(4'(k));
      idle(3 + k);
      bus.clear = 1'b1;
      step();
      bus.clear = 1'b0;
      idle(5);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.result_valid = ($urandom_range(0, 7) == 0);
      bus.result_in    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                     : 4'($urandom_range(0, 9));
      bus.clear        = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) bus.show_status = ~bus.show_status;
      bus.status_code  = 4'($urandom_range(0, 15));
      rst              = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    bus.result_valid = 1'b0;
    bus.clear = 1'b0;
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
